// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the single Ram port of the arbiter.
// The arbiter uses the slave view; requesters and the Ram model use the master view.
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              ram_mem_write;
  logic              ram_mem_read;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_write_data;
  logic [DATA_W-1:0] ram_data_in;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_in,
    output ack0, ack1, err0, err1, rdata0, rdata1,
    output ram_mem_write, ram_mem_read, ram_address, ram_write_data
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_in,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
    input  ram_mem_write, ram_mem_read, ram_address, ram_write_data
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter sequencing single-cycle accesses to a shared Ram.
// Each grant runs IDLE -> ACCESS -> DONE; out-of-range addresses never strobe the Ram.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input logic        clk,
  input logic        reset,
  ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q;
  logic              last_grant_q;
  logic              port_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack0_q, ack1_q, err0_q, err1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic grant_valid_d;
  logic grant_port_d;
  logic in_range;

  always_comb begin
    grant_valid_d = bus.req0 | bus.req1;
    grant_port_d  = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_port_d = ~last_grant_q;
    end else if (bus.req1) begin
      grant_port_d = 1'b1;
    end
  end

  assign in_range = (32'(addr_q) < 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid_d) begin
            last_grant_q <= grant_port_d;
            port_q       <= grant_port_d;
            we_q         <= grant_port_d ? bus.we1    : bus.we0;
            addr_q       <= grant_port_d ? bus.addr1  : bus.addr0;
            wdata_q      <= grant_port_d ? bus.wdata1 : bus.wdata0;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          // Ack/err are registered here so they appear exactly during DONE.
          ack0_q <= ~port_q;
          ack1_q <= port_q;
          err0_q <= ~port_q & ~in_range;
          err1_q <= port_q & ~in_range;
          if (!port_q) begin
            if (!in_range)  rdata0_q <= '0;
            else if (!we_q) rdata0_q <= bus.ram_data_in;
          end else begin
            if (!in_range)  rdata1_q <= '0;
            else if (!we_q) rdata1_q <= bus.ram_data_in;
          end
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Strobes are masked by reset so an interrupted access never reaches the Ram.
  assign bus.ram_mem_write  = (state_q == ACCESS) && !reset && in_range && we_q;
  assign bus.ram_mem_read   = (state_q == ACCESS) && !reset && in_range && !we_q;
  assign bus.ram_address    = addr_q;
  assign bus.ram_write_data = wdata_q;
  assign bus.ack0           = ack0_q;
  assign bus.ack1           = ack1_q;
  assign bus.err0           = err0_q;
  assign bus.err1           = err1_q;
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;
endmodule
